// File: rtl/joint_pos_counter.sv
// joint_pos_counter: one saturating position register per robot joint, stepped by
// up/down requests in level, edge or press-and-hold auto-repeat mode, with preset load.
module joint_pos_counter #(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 8,
    parameter int INIT       = 45,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = (1 << WIDTH) - 1,
    parameter int STEP       = 1,
    parameter int RPT_DELAY  = 25_000_000,
    parameter int RPT_PERIOD = 5_000_000,
    localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       cnt_up,
    input  logic [N_CH-1:0]       cnt_down,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [CHW-1:0]        load_ch,
    input  logic [WIDTH-1:0]      load_val,
    output logic [N_CH*WIDTH-1:0] pos,
    output logic [N_CH-1:0]       at_min,
    output logic [N_CH-1:0]       at_max
);
    localparam int               HW        = $clog2(RPT_DELAY + RPT_PERIOD + 1);
    localparam logic [WIDTH:0]   MIN_W     = (WIDTH+1)'(POS_MIN);
    localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(POS_MAX);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_N     = WIDTH'(POS_MIN);
    localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(POS_MAX);
    localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_N    = WIDTH'(INIT);
    localparam logic [HW-1:0]    H_DLY     = HW'(RPT_DELAY);
    localparam logic [HW-1:0]    H_RPT     = HW'(RPT_DELAY + RPT_PERIOD);
    localparam logic [HW-1:0]    H_RLD     = HW'(RPT_DELAY + 1);
    localparam logic [1:0]       MODE_EDGE = 2'b01;
    localparam logic [1:0]       MODE_RPT  = 2'b10;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] pos_q, pos_d;
        logic             prev_up_q, prev_dn_q;
        logic [HW-1:0]    h_q, h_d;
        logic             req_up, req_dn, rise, held, step, load_hit;
        logic [WIDTH:0]   pos_w, up_sum, load_w;

        // h_q holds the index of the next held sample; zero means no armed hold,
        // so a hold entered by mode switch or interrupted by a load never repeats.
        always_comb begin
            req_up   = cnt_up[i] & ~cnt_down[i];
            req_dn   = cnt_down[i] & ~cnt_up[i];
            rise     = (req_up & ~prev_up_q) | (req_dn & ~prev_dn_q);
            held     = (req_up & prev_up_q) | (req_dn & prev_dn_q);
            load_hit = load && (int'(load_ch) == i);
            pos_w    = {1'b0, pos_q};
            up_sum   = pos_w + STEP_W;
            load_w   = {1'b0, load_val};
            step     = 1'b0;
            h_d      = '0;
            case (mode)
                MODE_EDGE: step = rise;
                MODE_RPT: begin
                    if (rise) begin
                        step = 1'b1;
                        h_d  = HW'(1);
                    end else if (held && h_q != '0) begin
                        step = (h_q == H_DLY) || (h_q == H_RPT);
                        h_d  = (h_q == H_RPT) ? H_RLD : h_q + HW'(1);
                    end
                end
                default: step = req_up | req_dn;
            endcase

            pos_d = pos_q;
            if (load_hit) begin
                h_d = '0;
                if (load_w < MIN_W)      pos_d = MIN_N;
                else if (load_w > MAX_W) pos_d = MAX_N;
                else                     pos_d = load_val;
            end else if (step && req_up) begin
                pos_d = (up_sum > MAX_W) ? MAX_N : up_sum[WIDTH-1:0];
            end else if (step && req_dn) begin
                pos_d = (pos_w < MIN_W + STEP_W) ? MIN_N : pos_q - STEP_N;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pos_q     <= INIT_N;
                prev_up_q <= 1'b0;
                prev_dn_q <= 1'b0;
                h_q       <= '0;
            end else begin
                pos_q     <= pos_d;
                prev_up_q <= req_up;
                prev_dn_q <= req_dn;
                h_q       <= h_d;
            end
        end

        assign pos[i*WIDTH +: WIDTH] = pos_q;
        assign at_min[i]             = (pos_q == MIN_N);
        assign at_max[i]             = (pos_q == MAX_N);
    end
endmodule

// File: doc/joint_pos_counter.md
# joint_pos_counter

Multi-channel, parametrised position counter for the robotic-arm joints; one saturating position register per joint, driven by up/down requests from the control buttons or the automated-motion sequencer. It replaces the single 8-bit free-running counter. It adds configurable width, limits and step size, and a per-channel preset load. It also adds three counting modes: level, single-step-per-press, and press-and-hold auto-repeat. Its `pos` outputs feed the PWM servo generators directly.

## Interface
- `N_CH`, 4: number of joint channels.
- `WIDTH`, 8: position width in bits.
- `INIT`, 45: reset position of every channel.
- `POS_MIN`, 0: lower saturation limit; must satisfy `POS_MIN` ≤ `INIT` ≤ `POS_MAX`.
- `POS_MAX`, 2^`WIDTH`-1: upper saturation limit.
- `STEP`, 1: increment per step, from 1 to `POS_MAX`-`POS_MIN`.
- `RPT_DELAY`, 25_000_000: number of held cycles before the first auto-repeat; must be ≥ 1.
- `RPT_PERIOD`, 5_000_000: number of cycles between auto-repeats; must be ≥ 1.
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cnt_up` in `N_CH`: per-channel increment request; bit i controls channel i. Already synchronous to `clk`.
- `cnt_down` in `N_CH`: per-channel decrement request.
- `mode` in 2: counting mode, global to all channels. 00 = level, 01 = edge, 10 = repeat, 11 = treated as level.
- `load` in 1: preset strobe.
- `load_ch` in clog2(`N_CH`) (minimum 1): channel to preset. Values ≥ `N_CH` are ignored.
- `load_val` in `WIDTH`: preset value.
- `pos` out `N_CH`*`WIDTH`: channel i at bits [i*`WIDTH` +: `WIDTH`].
- `at_min` out `N_CH`: high when `pos`[i] == `POS_MIN`.
- `at_max` out `N_CH`: high when `pos`[i] == `POS_MAX`.

## Operation
- Per-channel state:
  - position register;
  - `prev_up` / `prev_dn` sample registers, updated every cycle in every mode;
  - hold counter `h`, sized to reach `RPT_DELAY`+`RPT_PERIOD`.
- Effective request per channel: `req_up` = `cnt_up` & ~`cnt_down`; `req_dn` = `cnt_down` & ~`cnt_up`. Both asserted is treated as no request and clears `h`.
- Step generation:
  - Level mode: a step on every cycle the request is high.
  - Edge mode: a step only on a rising edge (request high, previous sample low).
  - Repeat mode: `h` counts consecutive high samples of the active request, starting at 0 on the rising edge.
    - Steps occur at `h` = 0, `h` = `RPT_DELAY`, then every `RPT_PERIOD` cycles after that.
    - After each repeat step, `h` reloads to `RPT_DELAY`.
    - Release, or a direction change, clears `h`.
- Arithmetic is done in `WIDTH`+1 bits:
  - Up: `pos` = min(`pos`+`STEP`, `POS_MAX`).
  - Down: if `pos` < `POS_MIN`+`STEP`, then `pos` = `POS_MIN`; otherwise `pos` = `pos`-`STEP`.
  - Saturation is exact: there is never wrap-around, and a step at a limit produces no change.
- Load:
  - When `load` = 1 and `load_ch` < `N_CH`, the addressed channel takes `load_val` clamped to [`POS_MIN`, `POS_MAX`].
  - Load has priority over any step on that channel in the same cycle, and clears that channel's `h`.
  - All other channels count normally.
- Mode change takes effect on the next cycle. Because `prev_*` registers track in all modes, switching to edge or repeat mode while a button is held produces no step until that button is released and pressed again.
- `at_min` / `at_max` are combinational decodes of the position registers.

## Timing
- Reset (`rst` = 0, asynchronous): every `pos` = `INIT`, all `prev_*` = 0, all `h` = 0. `at_min` / `at_max` reflect `INIT`.
- Deassertion of `rst` is synchronous to `clk`, synchronised upstream. Reset mid-hold abandons the hold; a button still held after reset counts as a new rising edge.
- Latency: 1 cycle. A request sampled at edge k produces the new `pos` after edge k. Load has the same latency.
- Repeat mode, held for n samples: the number of steps is 1 + (n > `RPT_DELAY` ? 1 + floor((n-1-`RPT_DELAY`)/`RPT_PERIOD`) : 0).
- Channels are fully independent; requests on different channels in the same cycle are all applied.

## Test plan
The bench uses `N_CH`=4, `WIDTH`=8, `INIT`=45, `POS_MIN`=10, `POS_MAX`=200, `STEP`=1, `RPT_DELAY`=4, `RPT_PERIOD`=2.
- Reset then idle: all four `pos` = 45, `at_min` = `at_max` = 0. Assert `rst` = 0 mid-count: `pos` returns to 45 immediately, with no clock edge needed.
- Level mode, channel 0, `cnt_up` held 5 cycles: `pos`[0] = 50. `cnt_up` and `cnt_down` both held 3 cycles: `pos` unchanged.
- Edge mode, channel 1, `cnt_down` held 10 cycles: `pos`[1] = 44. Release then press 1 cycle: `pos`[1] = 43.
- Repeat mode, channel 2, `cnt_up` held 10 cycles: steps occur on samples 0, 4, 6 and 8, so `pos`[2] = 49.
- Load channel 3 with 250: `pos`[3] = 200 and `at_max`[3] = 1. Level `cnt_up` held: stays 200. Load 3: `pos`[3] = 10, `at_min`[3] = 1. `cnt_down` held: stays 10.
- Set `STEP`=7, level mode, starting from `pos` = 196: one up step gives 200. Starting from 15: one down step gives 10.
